// File: rtl/uart8_pkg.sv
// Shared types and constants for the 8N1 UART core.
package uart8_pkg;

   // Common state encoding for the receive and transmit FSMs.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uartState_t;

   localparam int DATA_BITS  = 8;
   localparam int OVERSAMPLE = 16;

   // Clocks per 16x receive tick (truncated integer division).
   function automatic int rxDivFor(input int clockRate, input int baudRate);
      return clockRate / (baudRate * OVERSAMPLE);
   endfunction

   // Clocks per transmitted bit (truncated integer division).
   function automatic int txDivFor(input int clockRate, input int baudRate);
      return clockRate / baudRate;
   endfunction

endpackage

// File: rtl/uart8_if.sv
// Parallel byte handshake between the fabric (master) and the UART core (slave).
interface uart8_if;
   logic       rxEn;
   logic       rxBusy;
   logic       rxDone;
   logic       rxErr;
   logic [7:0] out;
   logic       txEn;
   logic       txStart;
   logic [7:0] in;
   logic       txBusy;
   logic       txDone;

   modport master (
      output rxEn, txEn, txStart, in,
      input  rxBusy, rxDone, rxErr, out, txBusy, txDone
   );

   modport slave (
      input  rxEn, txEn, txStart, in,
      output rxBusy, rxDone, rxErr, out, txBusy, txDone
   );
endinterface

// File: rtl/uart8_baud_gen.sv
// Restartable divide-by-DIV tick generator. tick is high for the last clock of
// every DIV-clock period; holding restart clears the count so the first tick
// after release lands exactly DIV clocks later.
module uart8_baud_gen #(
   parameter int DIV = 78
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic tick
);
   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [W-1:0] countReg;

   assign tick = (countReg == W'(DIV - 1));

   // Free-running modulo-DIV counter, cleared while the owning FSM is idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         countReg <= '0;
      end else if (restart || tick) begin
         countReg <= '0;
      end else begin
         countReg <= countReg + W'(1);
      end
   end
endmodule

// File: rtl/uart8_core.sv
// Full-duplex 8N1 UART: 16x-oversampled receiver and 1x transmitter, each
// timed by its own restartable baud generator.
module uart8_core
   import uart8_pkg::*;
#(
   parameter int CLOCK_RATE = 12000000,
   parameter int BAUD_RATE  = 9600
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   rx,
   output logic   tx,
   uart8_if.slave bus
);
   localparam int RX_DIV = rxDivFor(CLOCK_RATE, BAUD_RATE);
   localparam int TX_DIV = txDivFor(CLOCK_RATE, BAUD_RATE);
   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam int BIT_W  = $clog2(DATA_BITS);

   localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

   // ---------------- receive side ----------------
   uartState_t        rxState;
   logic              rxMeta, rxSync;
   logic [TICK_W-1:0] rxTickCnt;
   logic [BIT_W-1:0]  rxBitCnt;
   logic [7:0]        rxShift;
   logic [7:0]        rxData;
   logic              rxBusyReg, rxDoneReg, rxErrReg;
   logic              rxTick;

   uart8_baud_gen #(.DIV(RX_DIV)) rxBaud (
      .clk    (clk),
      .rst_n  (rst_n),
      .restart(rxState == IDLE),
      .tick   (rxTick)
   );

   // Two-flop synchroniser, preset to the idle level so reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxMeta <= 1'b1;
         rxSync <= 1'b1;
      end else begin
         rxMeta <= rx;
         rxSync <= rxMeta;
      end
   end

   // Receive FSM: detect start, verify at mid-bit, then sample every 16 ticks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxState   <= IDLE;
         rxTickCnt <= '0;
         rxBitCnt  <= '0;
         rxShift   <= '0;
         rxData    <= '0;
         rxBusyReg <= 1'b0;
         rxDoneReg <= 1'b0;
         rxErrReg  <= 1'b0;
      end else begin
         rxDoneReg <= 1'b0;
         rxErrReg  <= 1'b0;
         if (!bus.rxEn) begin
            rxState   <= IDLE;
            rxTickCnt <= '0;
            rxBitCnt  <= '0;
            rxBusyReg <= 1'b0;
         end else begin
            unique case (rxState)
               IDLE: begin
                  rxBusyReg <= 1'b0;
                  if (rxSync == 1'b0) begin
                     rxState   <= START;
                     rxTickCnt <= '0;
                     rxBitCnt  <= '0;
                     rxBusyReg <= 1'b1;
                  end
               end
               START: if (rxTick) begin
                  if (rxTickCnt == MID_TICK) begin
                     rxTickCnt <= '0;
                     if (rxSync) begin
                        rxState   <= IDLE;
                        rxBusyReg <= 1'b0;
                     end else begin
                        rxState <= DATA;
                     end
                  end else begin
                     rxTickCnt <= rxTickCnt + TICK_W'(1);
                  end
               end
               DATA: if (rxTick) begin
                  rxTickCnt <= rxTickCnt + TICK_W'(1);
                  if (rxTickCnt == LAST_TICK) begin
                     rxShift <= {rxSync, rxShift[7:1]};
                     if (rxBitCnt == LAST_BIT) begin
                        rxState <= STOP;
                     end else begin
                        rxBitCnt <= rxBitCnt + BIT_W'(1);
                     end
                  end
               end
               STOP: if (rxTick) begin
                  rxTickCnt <= rxTickCnt + TICK_W'(1);
                  if (rxTickCnt == LAST_TICK) begin
                     rxState   <= IDLE;
                     rxBusyReg <= 1'b0;
                     if (rxSync) begin
                        rxData    <= rxShift;
                        rxDoneReg <= 1'b1;
                     end else begin
                        rxErrReg <= 1'b1;
                     end
                  end
               end
               default: rxState <= IDLE;
            endcase
         end
      end
   end

   assign bus.rxBusy = rxBusyReg;
   assign bus.rxDone = rxDoneReg;
   assign bus.rxErr  = rxErrReg;
   assign bus.out    = rxData;

   // ---------------- transmit side ----------------
   uartState_t       txState;
   logic [BIT_W-1:0] txBitCnt;
   logic [7:0]       txShift;
   logic             txBusyReg, txDoneReg;
   logic             txTick;

   uart8_baud_gen #(.DIV(TX_DIV)) txBaud (
      .clk    (clk),
      .rst_n  (rst_n),
      .restart(txState == IDLE),
      .tick   (txTick)
   );

   // Transmit FSM: each state holds its bit for one full TX_DIV period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         txState   <= IDLE;
         txBitCnt  <= '0;
         txShift   <= '0;
         tx        <= 1'b1;
         txBusyReg <= 1'b0;
         txDoneReg <= 1'b0;
      end else begin
         txDoneReg <= 1'b0;
         if (!bus.txEn) begin
            txState   <= IDLE;
            txBitCnt  <= '0;
            tx        <= 1'b1;
            txBusyReg <= 1'b0;
         end else begin
            unique case (txState)
               IDLE: begin
                  tx        <= 1'b1;
                  txBusyReg <= 1'b0;
                  if (bus.txStart) begin
                     txShift   <= bus.in;
                     txBitCnt  <= '0;
                     txState   <= START;
                     tx        <= 1'b0;
                     txBusyReg <= 1'b1;
                  end
               end
               START: if (txTick) begin
                  txState <= DATA;
                  tx      <= txShift[0];
                  txShift <= {1'b0, txShift[7:1]};
               end
               DATA: if (txTick) begin
                  if (txBitCnt == LAST_BIT) begin
                     txState <= STOP;
                     tx      <= 1'b1;
                  end else begin
                     txBitCnt <= txBitCnt + BIT_W'(1);
                     tx       <= txShift[0];
                     txShift  <= {1'b0, txShift[7:1]};
                  end
               end
               STOP: if (txTick) begin
                  txState   <= IDLE;
                  txBusyReg <= 1'b0;
                  txDoneReg <= 1'b1;
               end
               default: txState <= IDLE;
            endcase
         end
      end
   end

   assign bus.txBusy = txBusyReg;
   assign bus.txDone = txDoneReg;

endmodule

// File: tb/tb_uart8_core.sv
// Directed bench for uart8_core. A reduced clock rate (160 clocks per bit,
// exact 10-clock 16x tick) keeps the run short while exercising the same logic.
module tb_uart8_core;
   localparam int CLOCK_RATE = 1536000;
   localparam int BAUD_RATE  = 9600;
   localparam int BIT        = 160;   // clocks per nominal bit
   localparam int SKEW       = 165;   // ~1.03x nominal bit period

   logic clk      = 1'b0;
   logic rst_n    = 1'b0;
   logic rxDrv    = 1'bx;
   logic loopMode = 1'b0;
   logic tx;
   logic rxLine;

   uart8_if bus ();

   assign rxLine = loopMode ? tx : rxDrv;

   uart8_core #(.CLOCK_RATE(CLOCK_RATE), .BAUD_RATE(BAUD_RATE)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .rx   (rxLine),
      .tx   (tx),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int nChecks = 0;
   int nPassed = 0;
   int rxDoneCnt = 0;
   int rxErrCnt = 0;
   int txDoneCnt = 0;
   int busyLowCnt = 0;
   logic watchBusy = 1'b0;

   // Pulse and busy-gap monitors, sampled on the falling edge.
   always @(negedge clk) begin
      if (bus.rxDone === 1'b1) rxDoneCnt++;
      if (bus.rxErr === 1'b1) rxErrCnt++;
      if (bus.txDone === 1'b1) txDoneCnt++;
      if (watchBusy && bus.rxBusy !== 1'b1) busyLowCnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) nPassed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic waitClk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive nBits serial bits LSB first, each held for period clocks.
   task automatic sendBits(input logic [9:0] bits, input int nBits, input int period);
      for (int i = 0; i < nBits; i++) begin
         rxDrv = bits[i];
         waitClk(period);
      end
   endtask

   task automatic pulseTxStart(input logic [7:0] data);
      bus.in      = data;
      bus.txStart = 1'b1;
      waitClk(1);
      bus.txStart = 1'b0;
   endtask

   logic [9:0] frame;
   logic [9:0] rest;
   int doneBase, errBase, txBase;

   initial begin
      bus.rxEn    = 1'b0;
      bus.txEn    = 1'b0;
      bus.txStart = 1'b0;
      bus.in      = 8'h00;

      // ---- reset with rx unknown ----
      waitClk(5);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_rxBusy", 32'(bus.rxBusy), 32'd0);
      check("rst_rxDone", 32'(bus.rxDone), 32'd0);
      check("rst_rxErr", 32'(bus.rxErr), 32'd0);
      check("rst_out", 32'(bus.out), 32'h00);
      check("rst_txBusy", 32'(bus.txBusy), 32'd0);
      check("rst_txDone", 32'(bus.txDone), 32'd0);
      rxDrv = 1'b1;
      waitClk(2);
      rst_n = 1'b1;
      bus.rxEn = 1'b1;
      waitClk(20);
      check("idle_rxBusy", 32'(bus.rxBusy), 32'd0);

      // ---- receive 0x35 at nominal rate ----
      frame = {1'b1, 8'h35, 1'b0};
      doneBase = rxDoneCnt; errBase = rxErrCnt;
      rxDrv = 1'b0;
      waitClk(2);
      check("rx35_busy_early", 32'(bus.rxBusy), 32'd0);
      waitClk(1);
      check("rx35_busy_rise", 32'(bus.rxBusy), 32'd1);
      waitClk(BIT - 3);
      rest = frame >> 1;
      sendBits(rest, 9, BIT);
      waitClk(20);
      check("rx35_done", 32'(rxDoneCnt - doneBase), 32'd1);
      check("rx35_err", 32'(rxErrCnt - errBase), 32'd0);
      check("rx35_out", 32'(bus.out), 32'h35);
      check("rx35_busy_end", 32'(bus.rxBusy), 32'd0);

      // ---- +3% skewed frame delivered in two parts ----
      doneBase = rxDoneCnt; errBase = rxErrCnt;
      rxDrv = 1'b0;
      waitClk(5);
      watchBusy = 1'b1;
      waitClk(SKEW - 5);
      rest = frame >> 1;
      sendBits(rest, 5, SKEW);
      check("skew_part_done", 32'(rxDoneCnt - doneBase), 32'd0);
      check("skew_part_err", 32'(rxErrCnt - errBase), 32'd0);
      check("skew_part_out", 32'(bus.out), 32'h35);
      rest = frame >> 6;
      sendBits(rest, 3, SKEW);
      watchBusy = 1'b0;
      check("skew_busy_gaps", 32'(busyLowCnt), 32'd0);
      check("skew_busy_bit7", 32'(bus.rxBusy), 32'd1);
      sendBits(10'b1, 1, SKEW);
      waitClk(20);
      check("skew_done", 32'(rxDoneCnt - doneBase), 32'd1);
      check("skew_err", 32'(rxErrCnt - errBase), 32'd0);
      check("skew_out", 32'(bus.out), 32'h35);

      // ---- framing error: 0xA5 with stop bit 0 ----
      frame = {1'b0, 8'hA5, 1'b0};
      doneBase = rxDoneCnt; errBase = rxErrCnt;
      sendBits(frame, 9, BIT);
      rxDrv = 1'b0;            // stop bit low long enough to be sampled
      waitClk(BIT * 5 / 8);
      rxDrv = 1'b1;
      waitClk(2 * BIT);
      check("ferr_err", 32'(rxErrCnt - errBase), 32'd1);
      check("ferr_done", 32'(rxDoneCnt - doneBase), 32'd0);
      check("ferr_out", 32'(bus.out), 32'h35);

      // ---- glitch shorter than half a bit ----
      doneBase = rxDoneCnt; errBase = rxErrCnt;
      rxDrv = 1'b0;
      waitClk(40);
      rxDrv = 1'b1;
      waitClk(2 * BIT);
      check("glitch_done", 32'(rxDoneCnt - doneBase), 32'd0);
      check("glitch_err", 32'(rxErrCnt - errBase), 32'd0);
      check("glitch_busy", 32'(bus.rxBusy), 32'd0);
      check("glitch_out", 32'(bus.out), 32'h35);

      // ---- transmit 0x35, exact bit timing, ignored mid-frame start ----
      frame = {1'b1, 8'h35, 1'b0};
      txBase = txDoneCnt;
      bus.txEn = 1'b1;
      waitClk(1);
      pulseTxStart(8'h35);     // now in the first clock of the start bit
      for (int b = 0; b < 10; b++) begin
         check($sformatf("tx_first_b%0d", b), 32'(tx), 32'(frame[b]));
         check($sformatf("tx_busy_b%0d", b), 32'(bus.txBusy), 32'd1);
         if (b == 4) begin
            pulseTxStart(8'hFF);
            waitClk(BIT - 2);
         end else begin
            waitClk(BIT - 1);
         end
         check($sformatf("tx_last_b%0d", b), 32'(tx), 32'(frame[b]));
         waitClk(1);
      end
      check("tx_done_pulse", 32'(bus.txDone), 32'd1);
      check("tx_busy_end", 32'(bus.txBusy), 32'd0);
      check("tx_idle_line", 32'(tx), 32'd1);
      waitClk(BIT);
      check("tx_done_count", 32'(txDoneCnt - txBase), 32'd1);
      check("tx_stays_idle", 32'(tx), 32'd1);

      // ---- loopback 0xC3 ----
      loopMode = 1'b1;
      doneBase = rxDoneCnt; errBase = rxErrCnt; txBase = txDoneCnt;
      pulseTxStart(8'hC3);
      waitClk(11 * BIT);
      check("loop_out", 32'(bus.out), 32'hC3);
      check("loop_done", 32'(rxDoneCnt - doneBase), 32'd1);
      check("loop_err", 32'(rxErrCnt - errBase), 32'd0);
      check("loop_txdone", 32'(txDoneCnt - txBase), 32'd1);

      // ---- receiver disabled mid-frame ----
      doneBase = rxDoneCnt; errBase = rxErrCnt; txBase = txDoneCnt;
      pulseTxStart(8'h5A);
      waitClk(600);
      check("rxoff_busy_before", 32'(bus.rxBusy), 32'd1);
      bus.rxEn = 1'b0;
      waitClk(1);
      check("rxoff_busy_after", 32'(bus.rxBusy), 32'd0);
      waitClk(8 * BIT);
      check("rxoff_done", 32'(rxDoneCnt - doneBase), 32'd0);
      check("rxoff_err", 32'(rxErrCnt - errBase), 32'd0);
      check("rxoff_out", 32'(bus.out), 32'hC3);
      check("rxoff_txdone", 32'(txDoneCnt - txBase), 32'd1);

      // ---- transmitter disabled mid-frame ----
      txBase = txDoneCnt;
      pulseTxStart(8'h00);
      waitClk(500);
      check("txoff_line_low", 32'(tx), 32'd0);
      bus.txEn = 1'b0;
      waitClk(1);
      check("txoff_line", 32'(tx), 32'd1);
      check("txoff_busy", 32'(bus.txBusy), 32'd0);
      waitClk(10 * BIT);
      check("txoff_done", 32'(txDoneCnt - txBase), 32'd0);

      // ---- asynchronous reset mid-frame ----
      bus.txEn = 1'b1;
      waitClk(1);
      pulseTxStart(8'h00);
      waitClk(300);
      check("arst_pre_busy", 32'(bus.txBusy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_tx", 32'(tx), 32'd1);
      check("arst_txBusy", 32'(bus.txBusy), 32'd0);
      check("arst_out", 32'(bus.out), 32'h00);
      waitClk(3);
      rst_n = 1'b1;
      waitClk(3);

      $display("%0d/%0d checks passed", nPassed, nChecks);
      $finish;
   end
endmodule
